uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel stage directly downstream of the UART transmitter. It samples the one-bit-per-clock line and decodes the binary-ternary (btint) digit frames. It rebuilds each 4-element column and packs completed columns into a 4x4 btint matrix. The matrix is exposed in the same packed layout the transmitter consumes.

## Interface
- ROWS, 4: elements per column and columns per matrix (matrix is ROWS x ROWS).
- DIGITS, 8: btint digits per element; must be a multiple of 4 (one frame carries 4 digits).
- uart_receiver_clock  input  1  sole clock, rising edge.
- uart_receiver_reset  input  1  asynchronous, active-high reset.
- uart_receiver_input  input  1  serial line; idle high; one bit per clock.
- uart_receiver_output_btint_a  output  ROWS*ROWS*DIGITS  matrix "a" digit planes, packed.
- uart_receiver_output_btint_b  output  ROWS*ROWS*DIGITS  matrix "b" digit planes, packed.
- uart_receiver_output_overflow  output  ROWS*ROWS*2  overflow flags; always zero, because overflow is not transmitted.
- uart_receiver_column  output  32 signed  index of the most recently completed column.
- uart_receiver_column_valid  output  1  one-cycle pulse when a column is written to the matrix.
- uart_receiver_matrix_valid  output  1  one-cycle pulse when column ROWS-1 is written.
- uart_receiver_frame_error  output  1  one-cycle pulse on a bad stop bit.

## Operation
- Frame is 11 bits, LSB first:
  - 1 start bit (0).
  - 8 data bits in order a0,b0,a1,b1,a2,b2,a3,b3.
  - 2 stop bits (1,1).
- Element order within a column:
  - Each element takes DIGITS/4 frames. The first frame carries digits 3:0, the next carries 7:4.
  - Elements arrive in row order r = 0..ROWS-1.
- Element (r,c) is stored at slice [((ROWS-1-r)*ROWS + (ROWS-1-c))*DIGITS +: DIGITS] of btint_a and btint_b.
- Column index c:
  - Starts at 0 after reset.
  - Increments on each completed column and wraps from ROWS-1 to 0.
- Digits are assembled in a private column shadow buffer. The matrix registers change only when a column completes, and only the ROWS slices of column c are written.
- State machine:
  - IDLE: input 0 -> DATA, bit counter = 0. Input 1 -> stay.
  - DATA: capture the bit; even count -> a digit, odd count -> b digit, at digit position nibble*4 + count/2. After count 7 -> STOP1.
  - STOP1: input 1 -> STOP2. Input 0 -> pulse frame_error, discard the partial column (row, nibble and shadow cleared; c unchanged), -> RESYNC.
  - STOP2: input 1 -> advance nibble/row, -> IDLE. On column completion, write the shadow to the matrix, pulse column_valid, set uart_receiver_column = c, then advance c. Input 0 -> same error handling as STOP1.
  - RESYNC: wait for input 1, then -> IDLE. A 0 here is never taken as a start bit.
- matrix_valid pulses in the same cycle as column_valid when the completed c = ROWS-1.
- Reset (any time, including mid-frame):
  - State IDLE; all counters, shadow and matrix registers 0; uart_receiver_column = 0.
  - All pulse outputs 0; overflow output 0.

## Timing
- The line is sampled on every rising clock edge; no oversampling and no baud divider.
- Back-to-back frames are supported with zero idle gap: a start bit in the cycle immediately after STOP2 is accepted.
- column_valid, matrix_valid and the updated matrix/column outputs are registered. They are visible the cycle after the second stop bit of the last frame of the column is sampled.
- Column period at full rate: ROWS*(DIGITS/4)*11 = 88 cycles for the defaults.
- frame_error is registered: it is visible the cycle after the offending stop bit is sampled.
- Pulses are exactly one cycle wide.
- Outputs hold between updates; a framing error never alters the matrix or the column output.

## Test plan
- Single column, c=0, elements a = 0x01,0x80,0xFF,0x5A and b = 0x00,0x7F,0x0F,0xA5, sent back to back:
  - column_valid pulses once, 1 cycle after frame 8's last stop bit.
  - btint_a[127:120] = 0x01, [95:88] = 0x80, [63:56] = 0xFF, [31:24] = 0x5A; b slices match.
- Four columns, element value (r*4+c) in both a and b:
  - matrix_valid pulses once, with uart_receiver_column = 3.
  - The full matrix equals the transmitter input vector.
  - A 5th column then overwrites column 0 only.
- Second stop bit forced to 0 in frame 3 of column 1:
  - frame_error pulses once; no column_valid.
  - Next, a 0 on the line while in RESYNC is ignored.
  - After line goes high, a fresh full column is received as column 1.
- Inter-frame idle gaps of 0, 1 and 7 high cycles: decoded digits are identical in all three cases.
- Reset asserted at data bit 5 of frame 6:
  - All outputs 0 immediately (asynchronous).
  - After release, a full column decodes as column 0.
- Line held high for 200 cycles after reset: no pulses, outputs remain 0.

Source files
------------

// File: rtl/uart_receiver.sv
// Serial receiver for btint digit frames: rebuilds ROWS-element columns in a
// shadow buffer and commits each finished column into a ROWS x ROWS matrix.
module uart_receiver #(
    parameter int ROWS   = 4,
    parameter int DIGITS = 8
) (
    input  logic                          uart_receiver_clock,
    input  logic                          uart_receiver_reset,
    input  logic                          uart_receiver_input,
    output logic [ROWS*ROWS*DIGITS-1:0]   uart_receiver_output_btint_a,
    output logic [ROWS*ROWS*DIGITS-1:0]   uart_receiver_output_btint_b,
    output logic [ROWS*ROWS*2-1:0]        uart_receiver_output_overflow,
    output logic signed [31:0]            uart_receiver_column,
    output logic                          uart_receiver_column_valid,
    output logic                          uart_receiver_matrix_valid,
    output logic                          uart_receiver_frame_error
);
    localparam int NIB   = DIGITS / 4;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int COL_W = ROWS * DIGITS;
    localparam int IDX_W = $clog2(COL_W);
    localparam int MAT_W = ROWS * ROWS * DIGITS;

    typedef enum logic [2:0] {IDLE, DATA, STOP1, STOP2, RESYNC} state_t;

    state_t             state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [NIB_W-1:0]   nibble_q, nibble_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ROW_W-1:0]   col_q, col_d;
    logic [COL_W-1:0]   shadow_a_q, shadow_a_d;
    logic [COL_W-1:0]   shadow_b_q, shadow_b_d;
    logic [MAT_W-1:0]   mat_a_q, mat_a_d;
    logic [MAT_W-1:0]   mat_b_q, mat_b_d;
    logic [31:0]        column_q, column_d;
    logic               column_valid_q, column_valid_d;
    logic               matrix_valid_q, matrix_valid_d;
    logic               frame_error_q, frame_error_d;
    logic [IDX_W-1:0]   digit_idx;

    // Even data bits are a-digits, odd are b-digits; bit pairs step through the nibble.
    assign digit_idx = IDX_W'(int'(row_q) * DIGITS + int'(nibble_q) * 4 + int'(bit_cnt_q[2:1]));

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        nibble_d       = nibble_q;
        row_d          = row_q;
        col_d          = col_q;
        shadow_a_d     = shadow_a_q;
        shadow_b_d     = shadow_b_q;
        mat_a_d        = mat_a_q;
        mat_b_d        = mat_b_q;
        column_d       = column_q;
        column_valid_d = 1'b0;
        matrix_valid_d = 1'b0;
        frame_error_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!uart_receiver_input) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_cnt_q[0]) shadow_b_d[digit_idx] = uart_receiver_input;
                else              shadow_a_d[digit_idx] = uart_receiver_input;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = STOP1;
            end
            STOP1, STOP2: begin
                if (!uart_receiver_input) begin
                    // Bad stop bit: drop the partial column but keep the column index.
                    frame_error_d = 1'b1;
                    row_d         = '0;
                    nibble_d      = '0;
                    shadow_a_d    = '0;
                    shadow_b_d    = '0;
                    state_d       = RESYNC;
                end else if (state_q == STOP1) begin
                    state_d = STOP2;
                end else begin
                    state_d = IDLE;
                    if (nibble_q == NIB_W'(NIB - 1)) begin
                        nibble_d = '0;
                        if (row_q == ROW_W'(ROWS - 1)) begin
                            row_d = '0;
                            for (int r = 0; r < ROWS; r++) begin
                                for (int c = 0; c < ROWS; c++) begin
                                    if (int'(col_q) == c) begin
                                        mat_a_d[((ROWS-1-r)*ROWS + (ROWS-1-c))*DIGITS +: DIGITS] =
                                            shadow_a_q[r*DIGITS +: DIGITS];
                                        mat_b_d[((ROWS-1-r)*ROWS + (ROWS-1-c))*DIGITS +: DIGITS] =
                                            shadow_b_q[r*DIGITS +: DIGITS];
                                    end
                                end
                            end
                            column_valid_d = 1'b1;
                            matrix_valid_d = (col_q == ROW_W'(ROWS - 1));
                            column_d       = 32'(col_q);
                            col_d          = (col_q == ROW_W'(ROWS - 1)) ? '0 : col_q + ROW_W'(1);
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        nibble_d = nibble_q + NIB_W'(1);
                    end
                end
            end
            RESYNC: begin
                if (uart_receiver_input) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge uart_receiver_clock or posedge uart_receiver_reset) begin
        if (uart_receiver_reset) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            nibble_q       <= '0;
            row_q          <= '0;
            col_q          <= '0;
            shadow_a_q     <= '0;
            shadow_b_q     <= '0;
            mat_a_q        <= '0;
            mat_b_q        <= '0;
            column_q       <= '0;
            column_valid_q <= 1'b0;
            matrix_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            nibble_q       <= nibble_d;
            row_q          <= row_d;
            col_q          <= col_d;
            shadow_a_q     <= shadow_a_d;
            shadow_b_q     <= shadow_b_d;
            mat_a_q        <= mat_a_d;
            mat_b_q        <= mat_b_d;
            column_q       <= column_d;
            column_valid_q <= column_valid_d;
            matrix_valid_q <= matrix_valid_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign uart_receiver_output_btint_a  = mat_a_q;
    assign uart_receiver_output_btint_b  = mat_b_q;
    assign uart_receiver_output_overflow = '0;
    assign uart_receiver_column          = $signed(column_q);
    assign uart_receiver_column_valid    = column_valid_q;
    assign uart_receiver_matrix_valid    = matrix_valid_q;
    assign uart_receiver_frame_error     = frame_error_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame-level scoreboard predicts matrix, column and
// pulses; a negedge process compares every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_uart_receiver;
    localparam int ROWS = 4, DIGITS = 8, NIB = DIGITS / 4, MW = ROWS * ROWS * DIGITS;

    logic clk = 1'b0, rst = 1'b1, line = 1'b1;
    logic [MW-1:0] btint_a, btint_b;
    logic [ROWS*ROWS*2-1:0] ovf;
    logic signed [31:0] column;
    logic col_valid, mat_valid, ferr;

    int total = 0, bad = 0, cyc = 0;
    int cv_cnt = 0, mv_cnt = 0, fe_cnt = 0;

    // Scoreboard state: expected outputs plus the column being assembled.
    logic [MW-1:0] exp_a = '0, exp_b = '0;
    int exp_column = 0, model_c = 0, frames_in_col = 0;
    logic [DIGITS-1:0] part_a [ROWS], part_b [ROWS];
    bit ev_pending = 0, ev_colv = 0, ev_matv = 0, ev_err = 0;
    int ev_cyc = 0, ev_col = 0;
    logic [DIGITS-1:0] ev_a [ROWS], ev_b [ROWS];
    logic [DIGITS-1:0] col_a [ROWS], col_b [ROWS];

    uart_receiver #(.ROWS(ROWS), .DIGITS(DIGITS)) dut (
        .uart_receiver_clock          (clk),
        .uart_receiver_reset          (rst),
        .uart_receiver_input          (line),
        .uart_receiver_output_btint_a (btint_a),
        .uart_receiver_output_btint_b (btint_b),
        .uart_receiver_output_overflow(ovf),
        .uart_receiver_column         (column),
        .uart_receiver_column_valid   (col_valid),
        .uart_receiver_matrix_valid   (mat_valid),
        .uart_receiver_frame_error    (ferr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DIGITS-1:0] slice_of(input logic [MW-1:0] m, input int r, input int c);
        return m[((ROWS-1-r)*ROWS + (ROWS-1-c))*DIGITS +: DIGITS];
    endfunction

    always @(negedge clk) begin
        bit e_cv, e_mv, e_fe;
        e_cv = 0; e_mv = 0; e_fe = 0;
        if (ev_pending && cyc == ev_cyc) begin
            if (ev_colv) begin
                for (int r = 0; r < ROWS; r++) begin
                    exp_a[((ROWS-1-r)*ROWS + (ROWS-1-ev_col))*DIGITS +: DIGITS] = ev_a[r];
                    exp_b[((ROWS-1-r)*ROWS + (ROWS-1-ev_col))*DIGITS +: DIGITS] = ev_b[r];
                end
                exp_column = ev_col;
            end
            e_cv = ev_colv; e_mv = ev_matv; e_fe = ev_err;
            ev_pending = 0;
        end
        if (col_valid === 1'b1) cv_cnt++;
        if (mat_valid === 1'b1) mv_cnt++;
        if (ferr === 1'b1) fe_cnt++;
        check("column_valid", 128'(col_valid), 128'(e_cv));
        check("matrix_valid", 128'(mat_valid), 128'(e_mv));
        check("frame_error", 128'(ferr), 128'(e_fe));
        check("column", 128'(column), 128'(exp_column));
        check("btint_a", btint_a, exp_a);
        check("btint_b", btint_b, exp_b);
        check("overflow", 128'(ovf), 128'd0);
    end

    task automatic model_reset();
        exp_a = '0; exp_b = '0; exp_column = 0; model_c = 0; frames_in_col = 0; ev_pending = 0;
    endtask

    // Called right after the deciding stop bit is driven; the effect is due one cycle after it is sampled.
    task automatic model_frame(input logic [3:0] an, input logic [3:0] bn, input bit ok);
        ev_pending = 1; ev_cyc = cyc + 1; ev_colv = 0; ev_matv = 0; ev_err = 0;
        if (!ok) begin
            ev_err = 1;
            frames_in_col = 0;
        end else begin
            part_a[frames_in_col / NIB][(frames_in_col % NIB)*4 +: 4] = an;
            part_b[frames_in_col / NIB][(frames_in_col % NIB)*4 +: 4] = bn;
            frames_in_col++;
            if (frames_in_col == ROWS * NIB) begin
                ev_colv = 1;
                ev_matv = (model_c == ROWS - 1);
                ev_col = model_c;
                for (int r = 0; r < ROWS; r++) begin
                    ev_a[r] = part_a[r];
                    ev_b[r] = part_b[r];
                end
                model_c = (model_c + 1) % ROWS;
                frames_in_col = 0;
            end
        end
        if (!ev_colv && !ev_err) ev_pending = 0;
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk); #1; line = b;
    endtask

    task automatic send_idle(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    // bad: 0 = good frame, 1 = first stop bit low, 2 = second stop bit low
    task automatic send_frame(input logic [3:0] an, input logic [3:0] bn, input int bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit((i % 2 == 0) ? an[i/2] : bn[i/2]);
        send_bit((bad_stop == 1) ? 1'b0 : 1'b1);
        if (bad_stop == 1) model_frame(an, bn, 0);
        send_bit((bad_stop == 2) ? 1'b0 : 1'b1);
        if (bad_stop != 1) model_frame(an, bn, bad_stop == 0);
    endtask

    task automatic send_column(input int gap);
        for (int r = 0; r < ROWS; r++)
            for (int n = 0; n < NIB; n++) begin
                send_frame(col_a[r][n*4 +: 4], col_b[r][n*4 +: 4], 0);
                send_idle(gap);
            end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst = 1'b1; line = 1'b1; model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int cv0, mv0, fe0, c0;
        logic [127:0] lit;
        #12;
        check("reset_btint_a", btint_a, 128'd0);
        check("reset_column", 128'(column), 128'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Idle line: nothing may happen.
        send_idle(200);
        check("idle_cv_count", 128'(cv_cnt), 128'd0);
        check("idle_fe_count", 128'(fe_cnt), 128'd0);
        check("idle_btint_b", btint_b, 128'd0);

        // Single column with edge values.
        col_a[0] = 8'h01; col_a[1] = 8'h80; col_a[2] = 8'hFF; col_a[3] = 8'h5A;
        col_b[0] = 8'h00; col_b[1] = 8'h7F; col_b[2] = 8'h0F; col_b[3] = 8'hA5;
        send_column(0);
        send_idle(2);
        check("t1_cv_count", 128'(cv_cnt), 128'd1);
        check("t1_a_127_120", 128'(btint_a[127:120]), 128'h01);
        check("t1_a_95_88", 128'(btint_a[95:88]), 128'h80);
        check("t1_a_63_56", 128'(btint_a[63:56]), 128'hFF);
        check("t1_a_31_24", 128'(btint_a[31:24]), 128'h5A);
        check("t1_b_127_120", 128'(btint_b[127:120]), 128'h00);
        check("t1_b_95_88", 128'(btint_b[95:88]), 128'h7F);
        check("t1_b_63_56", 128'(btint_b[63:56]), 128'h0F);
        check("t1_b_31_24", 128'(btint_b[31:24]), 128'hA5);

        // Full matrix of r*4+c, then a fifth column overwriting column 0.
        pulse_reset();
        mv0 = mv_cnt;
        for (int c = 0; c < ROWS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                col_a[r] = 8'(r * 4 + c);
                col_b[r] = 8'(r * 4 + c);
            end
            send_column(0);
        end
        send_idle(2);
        check("t2_mv_count", 128'(mv_cnt - mv0), 128'd1);
        check("t2_column", 128'(column), 128'd3);
        check("t2_matrix_a", btint_a, 128'h000102030405060708090A0B0C0D0E0F);
        check("t2_matrix_b", btint_b, 128'h000102030405060708090A0B0C0D0E0F);
        for (int r = 0; r < ROWS; r++) begin
            col_a[r] = 8'(8'hC0 + r);
            col_b[r] = 8'(8'hC0 + r);
        end
        send_column(0);
        send_idle(2);
        check("t2_col0_rewrite", btint_a, 128'hC0010203C1050607C2090A0BC30D0E0F);
        check("t2_column_after", 128'(column), 128'd0);

        // Second stop bit low in frame 3 of column 1; a 0 in resync is ignored.
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(4'h1, 4'h2, 0);
        send_frame(4'h3, 4'h4, 0);
        send_frame(4'h5, 4'h6, 2);
        send_bit(1'b0);
        send_bit(1'b1);
        check("t3_fe_count", 128'(fe_cnt - fe0), 128'd1);
        check("t3_no_cv", 128'(cv_cnt - cv0), 128'd0);
        for (int r = 0; r < ROWS; r++) begin
            col_a[r] = 8'(8'h90 + r);
            col_b[r] = 8'(8'h69 - r);
        end
        send_column(0);
        send_idle(2);
        check("t3_column", 128'(column), 128'd1);
        check("t3_elem_a", 128'(slice_of(btint_a, 2, 1)), 128'h92);
        check("t3_elem_b", 128'(slice_of(btint_b, 3, 1)), 128'h66);

        // Identical column with different inter-frame gaps.
        for (int r = 0; r < ROWS; r++) begin
            col_a[r] = 8'($urandom);
            col_b[r] = 8'($urandom);
        end
        foreach (lit[i]) lit[i] = 1'b0;
        for (int g = 0; g < 3; g++) begin
            c0 = model_c;
            send_column((g == 0) ? 0 : (g == 1) ? 1 : 7);
            send_idle(2);
            for (int r = 0; r < ROWS; r++) begin
                check("gap_a", 128'(slice_of(btint_a, r, c0)), 128'(col_a[r]));
                check("gap_b", 128'(slice_of(btint_b, r, c0)), 128'(col_b[r]));
            end
        end

        // Random frames, gaps and framing errors against the scoreboard.
        for (int f = 0; f < 300; f++) begin
            int bs;
            bs = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 2)) : 0;
            send_frame(4'($urandom), 4'($urandom), bs);
            send_idle((bs == 2) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 2)));
        end

        // Asynchronous reset at data bit 5 of frame 6 of a column.
        while (frames_in_col != 0) send_frame(4'($urandom), 4'($urandom), 0);
        repeat (5) send_frame(4'($urandom), 4'($urandom), 0);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        @(posedge clk); #1;
        rst = 1'b1; line = 1'($urandom); model_reset();
        #1;
        check("arst_btint_a", btint_a, 128'd0);
        check("arst_btint_b", btint_b, 128'd0);
        check("arst_column", 128'(column), 128'd0);
        check("arst_pulses", 128'({col_valid, mat_valid, ferr}), 128'd0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; line = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            col_a[r] = 8'(8'h3C ^ r);
            col_b[r] = 8'(8'hE1 + r);
        end
        send_column(0);
        send_idle(2);
        check("post_rst_column", 128'(column), 128'd0);
        check("post_rst_elem_a", 128'(slice_of(btint_a, 1, 0)), 128'h3D);
        check("post_rst_elem_b", 128'(slice_of(btint_b, 3, 0)), 128'hE4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
